enemies_wavecontrol: RTL
========================

Name: enemies_waveControl

Overview:
- Game-flow controller directly upstream of every enemies_moveCollision instance.
- Drives each mover's restart_loc, pause and enemySpeed inputs.
- Tracks which enemies are still alive from their per-enemy hit signals, counts kills, and sequences waves of increasing speed until the player wins or dies.
- One instance serves all NUM_ENEMIES movers.

Parameters:
- NUM_ENEMIES, 4: number of enemy movers controlled.
- BASE_SPEED, 80: enemySpeed for wave 0, in 1/64 pixel per frame.
- SPEED_STEP, 16: speed increment per wave.
- MAX_SPEED, 400: speed ceiling (saturation value).
- INTER_WAVE_FRAMES, 120: frames of delay between a cleared wave and the next spawn.
- MAX_WAVES, 8: number of waves; clearing the last wave wins the game.

Ports:
- clk  in  1  system clock.
- resetN  in  1  reset.
- startOfFrame  in  1  one-clk pulse per video frame.
- startGame  in  1  one-clk pulse (debounced key).
- pauseBtn  in  1  one-clk pulse; toggles user pause.
- playerDead  in  1  level; player was hit.
- enemyHit  in  NUM_ENEMIES  bit i high (level, may last several clks) while enemy i collides with a shot.
- restart_loc  out  1  one-clk pulse; all movers return to their initial position.
- pause  out  1  freezes movers.
- enemySpeed  out  11  speed for all movers.
- waveNumber  out  4  current wave, 0-based.
- aliveMask  out  NUM_ENEMIES  bit i = enemy i alive.
- killCount  out  8  total kills this game.
- gameOver  out  1  player lost.
- gameWon  out  1  all waves cleared.

Interface notes:
- Reset is resetN: asynchronous, active-low. Clock is clk.
- All outputs are registered.

Behaviour:
- Reset values:
  - state IDLE, restart_loc 0, pause 1, enemySpeed BASE_SPEED, waveNumber 0.
  - aliveMask 0, killCount 0, gameOver 0, gameWon 0.
  - frameCnt 0, userPause 0.
- States: IDLE, SPAWN, PLAY, WAVE_CLEAR, GAME_OVER, WIN.
- IDLE:
  - pause=1.
  - On startGame: waveNumber<=0, killCount<=0, enemySpeed<=BASE_SPEED, gameOver<=0, gameWon<=0, go to SPAWN.
- SPAWN (exactly 1 clk):
  - restart_loc=1, aliveMask<=all ones, frameCnt<=0, userPause<=0, pause=0.
  - Next state is PLAY.
  - restart_loc is high for exactly the one clk spent in SPAWN, never otherwise.
- PLAY:
  - Per clk, kills = enemyHit & aliveMask, then aliveMask <= aliveMask & ~enemyHit.
  - killCount += popcount(kills), saturating at 255. A held enemyHit level counts only once, because the bit is already cleared.
  - Hits on already-dead enemies are ignored.
  - pause = userPause. pauseBtn toggles userPause. Kills are still recorded while paused.
  - playerDead -> GAME_OVER. It takes priority over a wave clear in the same clk; kills in that clk are still counted.
  - aliveMask == 0 (evaluated on the registered value) -> WAVE_CLEAR, frameCnt<=0.
- WAVE_CLEAR:
  - pause=0.
  - frameCnt increments on each startOfFrame.
  - When frameCnt reaches INTER_WAVE_FRAMES-1 and startOfFrame is high:
    - if waveNumber==MAX_WAVES-1: go to WIN.
    - else: waveNumber++, enemySpeed<=min(BASE_SPEED+(waveNumber+1)*SPEED_STEP, MAX_SPEED), go to SPAWN.
  - Speed arithmetic is done in 16 bits, then clamped; the result always fits 11 bits.
  - playerDead here -> GAME_OVER.
- GAME_OVER: gameOver=1, pause=1. startGame -> same actions as in IDLE, then SPAWN.
- WIN: gameWon=1, pause=1. startGame -> same actions as in IDLE, then SPAWN.
- startGame is ignored in SPAWN, PLAY and WAVE_CLEAR. pauseBtn is ignored outside PLAY.
- If resetN is asserted mid-wave, all registers return immediately to their reset values. No restart_loc is emitted until the next startGame.

Test Plan:
- Reset, then startGame at clk 10 -> restart_loc high only at clk 11; aliveMask=4'b1111 and pause=0 from clk 12; enemySpeed=80.
- In PLAY, hold enemyHit=4'b0001 for 5 clks -> killCount=1, aliveMask=4'b1110. Then enemyHit=4'b0110 for 1 clk -> killCount=3, aliveMask=4'b1000.
- Kill all 4 -> WAVE_CLEAR. After 120 startOfFrame pulses: restart_loc pulse, waveNumber=1, enemySpeed=96. Repeat through wave 7 -> gameWon=1, pause=1. With MAX_SPEED=100, wave 2 -> enemySpeed=100 (clamped).
- playerDead in the same clk as the last kill -> gameOver=1, killCount includes that kill, no WAVE_CLEAR. startGame -> killCount=0, waveNumber=0, restart_loc pulse.
- pauseBtn in PLAY -> pause=1. A second pauseBtn -> pause=0. pauseBtn and startGame pulses during WAVE_CLEAR -> no effect.
- Assert resetN low during WAVE_CLEAR -> all outputs return to their reset values asynchronously, with no restart_loc pulse.

Source files
------------

// File: rtl/enemies_wavecontrol.sv
// Game-flow controller for the enemy movers: spawns waves, tracks survivors and kills,
// and sequences speed-stepped waves until the player wins or dies.
module enemies_wavecontrol #(
    parameter int unsigned NUM_ENEMIES       = 4,
    parameter int unsigned BASE_SPEED        = 80,
    parameter int unsigned SPEED_STEP        = 16,
    parameter int unsigned MAX_SPEED         = 400,
    parameter int unsigned INTER_WAVE_FRAMES = 120,
    parameter int unsigned MAX_WAVES         = 8
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic                   startGame,
    input  logic                   pauseBtn,
    input  logic                   playerDead,
    input  logic [NUM_ENEMIES-1:0] enemyHit,
    output logic                   restart_loc,
    output logic                   pause,
    output logic [10:0]            enemySpeed,
    output logic [3:0]             waveNumber,
    output logic [NUM_ENEMIES-1:0] aliveMask,
    output logic [7:0]             killCount,
    output logic                   gameOver,
    output logic                   gameWon
);

    localparam int unsigned FRAME_W = $clog2(INTER_WAVE_FRAMES + 1);
    localparam int unsigned POP_W   = $clog2(NUM_ENEMIES + 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_SPAWN      = 3'd1;
    localparam logic [2:0] S_PLAY       = 3'd2;
    localparam logic [2:0] S_WAVE_CLEAR = 3'd3;
    localparam logic [2:0] S_GAME_OVER  = 3'd4;
    localparam logic [2:0] S_WIN        = 3'd5;

    logic [2:0]             r_state;
    logic [FRAME_W-1:0]     r_frame_cnt;
    logic                   r_user_pause;

    logic [2:0]             w_state_nxt;
    logic [FRAME_W-1:0]     w_frame_nxt;
    logic                   w_user_pause_nxt;
    logic                   w_restart_nxt;
    logic                   w_pause_nxt;
    logic [10:0]            w_speed_nxt;
    logic [3:0]             w_wave_nxt;
    logic [NUM_ENEMIES-1:0] w_alive_nxt;
    logic [7:0]             w_kill_nxt;
    logic                   w_over_nxt;
    logic                   w_won_nxt;

    logic [NUM_ENEMIES-1:0] w_kills;
    logic [POP_W-1:0]       w_kill_pop;
    logic [8:0]             w_kill_sum;
    logic [15:0]            w_speed_sum;
    logic [10:0]            w_speed_clamped;

    // Kill accounting: only enemies still alive can be killed, so a held hit counts once.
    always_comb begin
        w_kills    = enemyHit & aliveMask;
        w_kill_pop = '0;
        for (int i = 0; i < int'(NUM_ENEMIES); i++) begin
            w_kill_pop = w_kill_pop + POP_W'(w_kills[i]);
        end
        w_kill_sum = 9'(killCount) + 9'(w_kill_pop);
    end

    // Next-wave speed, computed wide then clamped to the ceiling.
    always_comb begin
        w_speed_sum = 16'(BASE_SPEED) + ((16'(waveNumber) + 16'd1) * 16'(SPEED_STEP));
        if (w_speed_sum > 16'(MAX_SPEED)) begin
            w_speed_clamped = 11'(MAX_SPEED);
        end else begin
            w_speed_clamped = w_speed_sum[10:0];
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_frame_nxt      = r_frame_cnt;
        w_user_pause_nxt = r_user_pause;
        w_speed_nxt      = enemySpeed;
        w_wave_nxt       = waveNumber;
        w_alive_nxt      = aliveMask;
        w_kill_nxt       = killCount;

        case (r_state)
            S_IDLE, S_GAME_OVER, S_WIN: begin
                if (startGame) begin
                    w_wave_nxt  = '0;
                    w_kill_nxt  = '0;
                    w_speed_nxt = 11'(BASE_SPEED);
                    w_state_nxt = S_SPAWN;
                end
            end
            S_SPAWN: begin
                w_alive_nxt      = '1;
                w_frame_nxt      = '0;
                w_user_pause_nxt = 1'b0;
                w_state_nxt      = S_PLAY;
            end
            S_PLAY: begin
                w_alive_nxt      = aliveMask & ~enemyHit;
                w_kill_nxt       = w_kill_sum[8] ? 8'hFF : w_kill_sum[7:0];
                w_user_pause_nxt = r_user_pause ^ pauseBtn;
                if (playerDead) begin
                    w_state_nxt = S_GAME_OVER;
                end else if (aliveMask == '0) begin
                    w_frame_nxt = '0;
                    w_state_nxt = S_WAVE_CLEAR;
                end
            end
            S_WAVE_CLEAR: begin
                if (playerDead) begin
                    w_state_nxt = S_GAME_OVER;
                end else if (startOfFrame) begin
                    if (r_frame_cnt == FRAME_W'(INTER_WAVE_FRAMES - 1)) begin
                        if (waveNumber == 4'(MAX_WAVES - 1)) begin
                            w_state_nxt = S_WIN;
                        end else begin
                            w_wave_nxt  = waveNumber + 4'd1;
                            w_speed_nxt = w_speed_clamped;
                            w_state_nxt = S_SPAWN;
                        end
                    end else begin
                        w_frame_nxt = r_frame_cnt + FRAME_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Registered outputs follow the state being entered.
        w_restart_nxt = (w_state_nxt == S_SPAWN);
        w_over_nxt    = (w_state_nxt == S_GAME_OVER);
        w_won_nxt     = (w_state_nxt == S_WIN);
        case (w_state_nxt)
            S_SPAWN, S_WAVE_CLEAR: w_pause_nxt = 1'b0;
            S_PLAY:                w_pause_nxt = w_user_pause_nxt;
            default:               w_pause_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state      <= S_IDLE;
            r_frame_cnt  <= '0;
            r_user_pause <= 1'b0;
            restart_loc  <= 1'b0;
            pause        <= 1'b1;
            enemySpeed   <= 11'(BASE_SPEED);
            waveNumber   <= '0;
            aliveMask    <= '0;
            killCount    <= '0;
            gameOver     <= 1'b0;
            gameWon      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_cnt  <= w_frame_nxt;
            r_user_pause <= w_user_pause_nxt;
            restart_loc  <= w_restart_nxt;
            pause        <= w_pause_nxt;
            enemySpeed   <= w_speed_nxt;
            waveNumber   <= w_wave_nxt;
            aliveMask    <= w_alive_nxt;
            killCount    <= w_kill_nxt;
            gameOver     <= w_over_nxt;
            gameWon      <= w_won_nxt;
        end
    end

endmodule
